// File: rtl/radiobox_pkg.sv
// radiobox_pkg: shared sweep FSM state type and default widths for the sweep controller.
package radiobox_pkg;

    localparam int INC_W_DEF   = 48;
    localparam int STEPS_W_DEF = 16;
    localparam int DWELL_W_DEF = 32;

    typedef enum logic [2:0] {IDLE, LOAD, DWELL, STEP, DONE} sweep_state_t;

endpackage

// File: rtl/radiobox_dwell_timer.sv
// radiobox_dwell_timer: down-counter that flags the last cycle of a len-cycle window started by load.
module radiobox_dwell_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    // expire marks the final cycle of the window; len 0 and 1 both give a one-cycle window
    always_comb begin
        cnt_d  = load ? ((len > W'(1)) ? len - W'(1) : '0)
                      : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
        expire = load ? (len <= W'(1)) : (cnt_q == W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/radiobox_sweep_ctrl.sv
// radiobox_sweep_ctrl: stepped OSC phase-increment sweep with dwell timing, abort and auto-loop.
// Define RADIOBOX_SWEEP_PHASE_RST_EN to pulse osc_phase_rst_o with every LOAD strobe.
module radiobox_sweep_ctrl
    import radiobox_pkg::*;
#(
    parameter int INC_W   = INC_W_DEF,
    parameter int STEPS_W = STEPS_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_adc_125mhz,
    input  logic               adc_rstn_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [INC_W-1:0]   cfg_start_inc,
    input  logic [INC_W-1:0]   cfg_step_inc,
    input  logic               cfg_step_dn,
    input  logic [STEPS_W-1:0] cfg_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    output logic [INC_W-1:0]   osc_inc_o,
    output logic               osc_inc_ld_o,
    output logic               osc_phase_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [STEPS_W-1:0] step_idx_o
);

    sweep_state_t       state_q, state_d;
    logic [INC_W-1:0]   inc_q, inc_d, step_q, step_d;
    logic [STEPS_W-1:0] idx_q, idx_d, steps_q, steps_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dn_q, dn_d, loop_q, loop_d;
    logic               ld, expire;

    assign ld = (state_q == LOAD) || (state_q == STEP);

    radiobox_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk    (clk_adc_125mhz),
        .rst_n  (adc_rstn_i),
        .load   (ld),
        .len    (dwell_q),
        .expire (expire)
    );

    // Registers update on entry to LOAD/STEP so the strobe cycle already shows the new increment
    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        idx_d   = idx_q;
        step_d  = step_q;
        dn_d    = dn_q;
        steps_d = steps_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE:              state_d = start_i ? LOAD : IDLE;
            LOAD, STEP, DWELL: state_d = expire ? ((idx_q == steps_q) ? DONE : STEP) : DWELL;
            DONE:              state_d = loop_q ? LOAD : IDLE;
            default:           state_d = IDLE;
        endcase
        if (stop_i) state_d = IDLE;
        if (state_d == LOAD) begin
            inc_d   = cfg_start_inc;
            idx_d   = '0;
            step_d  = cfg_step_inc;
            dn_d    = cfg_step_dn;
            steps_d = cfg_steps;
            dwell_d = cfg_dwell;
            loop_d  = cfg_loop;
        end
        if (state_d == STEP) begin
            inc_d = dn_q ? inc_q - step_q : inc_q + step_q;
            idx_d = idx_q + STEPS_W'(1);
        end
    end

    always_ff @(posedge clk_adc_125mhz or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= IDLE;
            inc_q   <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            dn_q    <= 1'b0;
            steps_q <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            dn_q    <= dn_d;
            steps_q <= steps_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
        end
    end

    assign osc_inc_o    = inc_q;
    assign osc_inc_ld_o = ld;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign step_idx_o   = idx_q;

`ifdef RADIOBOX_SWEEP_PHASE_RST_EN
    assign osc_phase_rst_o = state_q == LOAD;
`else
    assign osc_phase_rst_o = 1'b0;
`endif

endmodule

// File: doc/radiobox_sweep_ctrl.md
RADIOBOX_SWEEP_CTRL -- requirements
Module: radiobox_sweep_ctrl

Interface
REQ-001 SHALL have parameter INC_W, default 48, meaning OSC phase-increment width.
REQ-002 SHALL have parameter STEPS_W, default 16, meaning step-counter width.
REQ-003 SHALL have parameter DWELL_W, default 32, meaning dwell-counter width.
REQ-004 SHALL have port clk_adc_125mhz, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port adc_rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle start pulse.
REQ-007 SHALL have port stop_i, input, 1 bit: single-cycle abort pulse.
REQ-008 SHALL have port cfg_start_inc, input, INC_W bits: first increment of the sweep.
REQ-009 SHALL have port cfg_step_inc, input, INC_W bits: increment delta per step.
REQ-010 SHALL have port cfg_step_dn, input, 1 bit: 1 subtracts the delta, 0 adds it.
REQ-011 SHALL have port cfg_steps, input, STEPS_W bits: number of steps after the start value.
REQ-012 SHALL have port cfg_dwell, input, DWELL_W bits: clock cycles per frequency.
REQ-013 SHALL have port cfg_loop, input, 1 bit: restart the sweep automatically after it completes.
REQ-014 SHALL have port osc_inc_o, output, INC_W bits: increment driven to OSC1.
REQ-015 SHALL have port osc_inc_ld_o, output, 1 bit: one-cycle strobe marking osc_inc_o as new.
REQ-016 SHALL have port osc_phase_rst_o, output, 1 bit: one-cycle OSC phase-reset strobe.
REQ-017 SHALL have port busy_o, output, 1 bit: high while a sweep is active.
REQ-018 SHALL have port done_o, output, 1 bit: one-cycle end-of-sweep pulse.
REQ-019 SHALL have port step_idx_o, output, STEPS_W bits: current step index.

Function
REQ-020 SHALL implement an FSM with the states IDLE, LOAD, DWELL, STEP and DONE.
REQ-021 In IDLE, start_i SHALL move the FSM to LOAD; start_i in any other state SHALL be ignored.
REQ-022 In LOAD (1 cycle), the block SHALL latch all cfg_* inputs, set osc_inc_o=cfg_start_inc, set step_idx_o=0, assert osc_inc_ld_o, then enter DWELL.
REQ-023 Changes to cfg_* after LOAD SHALL have no effect until the next LOAD.
REQ-024 DWELL SHALL last exactly max(cfg_dwell,1) cycles measured from the ld strobe, so consecutive ld strobes are exactly max(D,1) cycles apart.
REQ-025 On dwell expiry, the FSM SHALL go to DONE if step_idx_o==cfg_steps, otherwise to STEP.
REQ-026 STEP (1 cycle) SHALL compute osc_inc_o ± cfg_step_inc modulo 2^INC_W (wrap, no saturation), increment step_idx_o, assert osc_inc_ld_o, then return to DWELL.
REQ-027 DONE (1 cycle) SHALL assert done_o, then go to LOAD if the latched loop bit is set, otherwise to IDLE.
REQ-028 Latency: start_i at cycle N SHALL produce the first ld strobe at N+1 and done_o at N+1+(cfg_steps+1)*max(D,1).
REQ-029 stop_i in any state SHALL force IDLE on the next edge; no ld or done strobe is issued that cycle; osc_inc_o and step_idx_o hold their values.
REQ-030 When start_i and stop_i are asserted together, stop SHALL win and the FSM SHALL stay in or return to IDLE.
REQ-031 busy_o SHALL be 1 in LOAD, DWELL, STEP and DONE, and 0 in IDLE.
REQ-032 cfg_steps=0 SHALL produce a single frequency: one ld strobe, one dwell, then done_o.

Reset
REQ-033 While adc_rstn_i=0, all outputs SHALL be 0, the FSM SHALL be IDLE and the counters SHALL be 0, regardless of clock activity.
REQ-034 Reset asserted mid-sweep SHALL abort immediately; after release, the block SHALL wait in IDLE for start_i.

Configuration
REQ-035 With RADIOBOX_SWEEP_PHASE_RST_EN defined, osc_phase_rst_o SHALL pulse in the same cycle as every LOAD ld strobe (not on STEP strobes).
REQ-036 Without RADIOBOX_SWEEP_PHASE_RST_EN, osc_phase_rst_o SHALL be tied to 0 and no related logic shall be generated.

Structure
REQ-037 Package radiobox_pkg SHALL hold the sweep_state_t enum and the INC_W, STEPS_W and DWELL_W default constants.
REQ-038 The dwell counter SHALL be a sub-module, radiobox_dwell_timer: inputs load and len, output expire, counting down.

Verification
REQ-039 start_inc=0x10000, step=0x10000 up, steps=3, dwell=4 -> ld at N+1, N+5, N+9, N+13 with inc 0x10000, 0x20000, 0x30000, 0x40000; done_o at N+17.
REQ-040 start_inc=0x000000000005, step=0x10 down, steps=1, dwell=2 -> second inc=0xFFFFFFFFFFF5 (wrap).
REQ-041 dwell=0, steps=2 -> ld strobes on consecutive cycles (N+1, N+2, N+3); done_o at N+4.
REQ-042 loop=1, steps=1, dwell=3 -> after done_o, the next cycle shows LOAD ld with start_inc; busy_o stays 1 throughout.
REQ-043 stop_i asserted 2 cycles after the second ld strobe -> IDLE next cycle, busy_o=0, osc_inc_o holds the second value, no done_o; start_i+stop_i together in IDLE -> stays IDLE.
REQ-044 adc_rstn_i pulsed low mid-DWELL -> all outputs 0 asynchronously; a build with RADIOBOX_SWEEP_PHASE_RST_EN defined shows osc_phase_rst_o coincident only with LOAD strobes.
